medio_sumador: RTL and testbench
================================

Name: medio_sumador

Overview:
- Parameterised binary adder built as a ripple chain of half-adder bit cells.
- Default configuration (WIDTH=1, REG_OUT=0) is a single-bit, purely combinational half adder.
- carryIn is present on the port list for drop-in compatibility with the full-adder footprint. It is ignored unless the optional feature is compiled in.
- Used as a leaf arithmetic primitive in the CPU datapath (ALU adder slices, PC increment).

Parameters:
- WIDTH, 1, operand/sum width in bits (>=1).
- REG_OUT, 0, 0 = combinational outputs; 1 = outputs registered on clk (one-cycle latency).

Ports:
- clk  input  1  clock, rising edge; used only when REG_OUT=1.
- rst_n  input  1  asynchronous active-low reset; used only when REG_OUT=1.
- operandX  input  WIDTH  addend X, unsigned.
- operandY  input  WIDTH  addend Y, unsigned.
- carryIn  input  1  carry into bit 0; honoured only with MEDIO_SUM_CARRYIN_EN.
- sum  output  WIDTH  (operandX + operandY [+ carryIn]) mod 2^WIDTH.
- carryOut  output  1  bit WIDTH of the full-precision sum.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Arithmetic: {carryOut, sum} = operandX + operandY + cin_eff, computed at WIDTH+1 bits, unsigned.
  - cin_eff = 0 by default.
  - cin_eff = carryIn with MEDIO_SUM_CARRYIN_EN.
- Per-bit cell: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin_eff.
- WIDTH=1 without the feature: sum = X ^ Y, carryOut = X & Y.
- Wrap-around: an all-ones + 1 result gives sum = 0, carryOut = 1. Ripple-carry semantics, no saturation.
- REG_OUT=0:
  - sum/carryOut are pure combinational functions of the inputs, with zero latency.
  - clk/rst_n are unused; no state exists.
  - Outputs are not affected by reset.
- REG_OUT=1:
  - The combinational result is captured on every rising clk. Outputs reflect the inputs present at the previous edge (latency 1, throughput 1/cycle).
  - rst_n low forces sum=0 and carryOut=0 immediately, independent of clk.
  - Deassertion is sampled at the next clk edge; the first capture happens at the first rising edge with rst_n high.
  - Reset asserted mid-stream discards the in-flight result.
- X/Z on any input propagates to the outputs; the block adds no masking.
- No handshake: every cycle/evaluation is valid.

Optional Feature:
- Macro: MEDIO_SUM_CARRYIN_EN.
- Defined: carryIn feeds c_0, turning the block into a full adder. Example: X=1, Y=1, carryIn=1 -> sum=1, carryOut=1.
- Undefined: c_0 is tied to 0 and carryIn is left unconnected internally (lint waiver). Example: X=1, Y=1, carryIn=1 -> sum=0, carryOut=1.

Decomposition:
- Shared package medio_sum_pkg:
  - constant MEDIO_SUM_DEFAULT_WIDTH = 1.
  - localparam helper for the WIDTH+1 result width.
  - typedef of the {carry, sum} result struct for users that bundle outputs.
- One sub-module: medio_sum_bit (single-bit adder cell: a, b, c_in -> s, c_out). It is instantiated WIDTH times in a generate loop.
- The top level holds the carry chain wiring, the cin_eff mux under the macro and the optional REG_OUT output register.

Test Plan:
- WIDTH=1, REG_OUT=0, feature off: sweep all 8 {X,Y,carryIn} combinations.
  - X=1, Y=1 -> sum=0, carryOut=1.
  - X=1, Y=0 -> sum=1, carryOut=0.
  - carryIn has no effect in any case.
- WIDTH=1, feature on: X=1, Y=1, carryIn=1 -> sum=1, carryOut=1. X=0, Y=0, carryIn=1 -> sum=1, carryOut=0.
- WIDTH=8, feature off, wrap-around: X=8'hFF, Y=8'h01 -> sum=8'h00, carryOut=1. X=8'h7F, Y=8'h01 -> sum=8'h80, carryOut=0.
- Random regression: WIDTH=8, 1000 random X/Y/carryIn vectors checked against a behavioural {carryOut,sum} = X+Y(+carryIn) model. Run with and without the macro.
- REG_OUT=1 latency and reset:
  - Apply X=3, Y=5 (WIDTH=4) before edge n -> sum=4'h8, carryOut=0 visible after edge n only.
  - Pull rst_n low between edges -> sum=0 and carryOut=0 immediately, with no clock required.
- REG_OUT=1 reset release: hold inputs X=1, Y=1 while releasing rst_n -> outputs stay 0 until the first rising clk with rst_n high, then sum=2 and carryOut=0 (WIDTH=4).

Source files
------------

// File: rtl/medio_sum_pkg.sv
// Shared definitions for the medio_sumador adder family.
// Contents: default width, result-width helper, bundled {carry, sum} result type.
package medio_sum_pkg;

  localparam int unsigned MEDIO_SUM_DEFAULT_WIDTH = 1;

  // Width of the full-precision result: operand width plus the carry bit.
  function automatic int unsigned resultWidth(input int unsigned w);
    return w + 1;
  endfunction

  // Bundled result for users that carry {carry, sum} around as one word.
  typedef struct packed {
    logic                               carry;
    logic [MEDIO_SUM_DEFAULT_WIDTH-1:0] sum;
  } medioSumResult_t;

endpackage

// File: rtl/medio_sum_if.sv
// Operand/result bundle for medio_sumador.
// master: drives operandX, operandY, carryIn; receives sum, carryOut.
// slave : the adder side; receives the operands, drives the result.
interface medio_sum_if
  import medio_sum_pkg::*;
#(
  parameter int unsigned WIDTH = MEDIO_SUM_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] operandX;
  logic [WIDTH-1:0] operandY;
  logic             carryIn;
  logic [WIDTH-1:0] sum;
  logic             carryOut;

  modport master (
    output operandX,
    output operandY,
    output carryIn,
    input  sum,
    input  carryOut
  );

  modport slave (
    input  operandX,
    input  operandY,
    input  carryIn,
    output sum,
    output carryOut
  );

endinterface

// File: rtl/medio_sum_bit.sv
// Single-bit adder cell of the ripple chain.
// Ports: a, b (operand bits), c_in (carry in) -> s (sum bit), c_out (carry out).
module medio_sum_bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic halfSum;

  // Half-adder pair: the carry propagates only when exactly one operand bit is set.
  assign halfSum = a ^ b;
  assign s       = halfSum ^ c_in;
  assign c_out   = (a & b) | (c_in & halfSum);

endmodule

// File: rtl/medio_sumador.sv
// Parameterised ripple-carry adder built from medio_sum_bit cells.
// Ports: clk, rst_n (async active-low; only used when REG_OUT=1),
//        bus (medio_sum_if.slave: operandX, operandY, carryIn -> sum, carryOut).
// Parameters: WIDTH (operand width, >=1), REG_OUT (0 = combinational, 1 = one-cycle registered).
// Build option: MEDIO_SUM_CARRYIN_EN routes carryIn into bit 0; otherwise carryIn is ignored.
module medio_sumador
  import medio_sum_pkg::*;
#(
  parameter int unsigned WIDTH   = MEDIO_SUM_DEFAULT_WIDTH,
  parameter bit          REG_OUT = 1'b0
)(
  input  logic        clk,
  input  logic        rst_n,
  medio_sum_if.slave  bus
);

  localparam int unsigned RES_W = resultWidth(WIDTH);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sumComb;

  // Carry into bit 0.
`ifdef MEDIO_SUM_CARRYIN_EN
  assign carry[0] = bus.carryIn;
`else
  logic unusedCarryIn;
  assign carry[0]      = 1'b0;
  assign unusedCarryIn = bus.carryIn;
`endif

  // Ripple chain.
  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    medio_sum_bit uBit (
      .a     (bus.operandX[i]),
      .b     (bus.operandY[i]),
      .c_in  (carry[i]),
      .s     (sumComb[i]),
      .c_out (carry[i+1])
    );
  end

  if (REG_OUT) begin : gReg
    logic [RES_W-1:0] resultQ;

    // Output register; reset clears any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        resultQ <= '0;
      end else begin
        resultQ <= {carry[WIDTH], sumComb};
      end
    end

    assign bus.sum      = resultQ[WIDTH-1:0];
    assign bus.carryOut = resultQ[WIDTH];
  end else begin : gComb
    // Purely combinational: clock and reset have no role here.
    logic unusedClkRst;
    assign unusedClkRst = clk ^ rst_n;

    assign bus.sum      = sumComb;
    assign bus.carryOut = carry[WIDTH];
  end

endmodule

// File: tb/tb_medio_sumador.sv
// Bench for medio_sumador: WIDTH=1 and WIDTH=8 combinational instances plus a
// WIDTH=4 registered instance, checked against an arithmetic reference model.
module tb_medio_sumador;

`ifdef MEDIO_SUM_CARRYIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  int nCompared   = 0;
  int nMismatched = 0;

  medio_sum_if #(.WIDTH(1)) bus1 ();
  medio_sum_if #(.WIDTH(8)) bus8 ();
  medio_sum_if #(.WIDTH(4)) bus4 ();

  medio_sumador #(.WIDTH(1), .REG_OUT(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  medio_sumador #(.WIDTH(8), .REG_OUT(1'b0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  medio_sumador #(.WIDTH(4), .REG_OUT(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: full-precision unsigned sum truncated to w+1 bits.
  function automatic logic [8:0] refAdd(input int unsigned w, input int unsigned x,
                                        input int unsigned y, input bit cin);
    int unsigned total;
    total = x + y + ((CIN_EN && cin) ? 1 : 0);
    return 9'(total % (1 << (w + 1)));
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] obs1();
    return 9'({bus1.carryOut, bus1.sum});
  endfunction
  function automatic logic [8:0] obs8();
    return 9'({bus8.carryOut, bus8.sum});
  endfunction
  function automatic logic [8:0] obs4();
    return 9'({bus4.carryOut, bus4.sum});
  endfunction

  initial begin
    logic [8:0]  expQ[$];
    logic [7:0]  rx;
    logic [7:0]  ry;
    logic        rc;
    logic [8:0]  spot;

    rst_n = 1'b0;
    bus1.operandX = '0; bus1.operandY = '0; bus1.carryIn = 1'b0;
    bus8.operandX = '0; bus8.operandY = '0; bus8.carryIn = 1'b0;
    bus4.operandX = 4'd7; bus4.operandY = 4'd6; bus4.carryIn = 1'b1;
    #1;
    check("reg_reset_state", obs4(), 9'd0);

    // WIDTH=1 exhaustive sweep over {X, Y, carryIn}.
    for (int v = 0; v < 8; v++) begin
      bus1.operandX = v[2];
      bus1.operandY = v[1];
      bus1.carryIn  = v[0];
      #1;
      check($sformatf("w1_sweep_%0d", v), obs1(),
            refAdd(1, int'(v[2]), int'(v[1]), v[0]));
    end

    // Spot values from the feature description, written as constants.
    bus1.operandX = 1'b1; bus1.operandY = 1'b1; bus1.carryIn = 1'b1;
    #1;
    spot = CIN_EN ? 9'b11 : 9'b10;
    check("w1_x1y1c1", obs1(), spot);
    bus1.operandX = 1'b1; bus1.operandY = 1'b0; bus1.carryIn = 1'b0;
    #1;
    check("w1_x1y0", obs1(), 9'b01);

    // WIDTH=8 wrap-around boundaries.
    bus8.operandX = 8'hFF; bus8.operandY = 8'h01; bus8.carryIn = 1'b0;
    #1;
    check("w8_ff_plus_1", obs8(), 9'h100);
    bus8.operandX = 8'h7F; bus8.operandY = 8'h01; bus8.carryIn = 1'b0;
    #1;
    check("w8_7f_plus_1", obs8(), 9'h080);
    bus8.operandX = 8'hFF; bus8.operandY = 8'hFF; bus8.carryIn = 1'b1;
    #1;
    check("w8_ff_ff_c1", obs8(), refAdd(8, 255, 255, 1'b1));

    // WIDTH=8 random regression.
    for (int n = 0; n < 1000; n++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rc = 1'($urandom);
      bus8.operandX = rx; bus8.operandY = ry; bus8.carryIn = rc;
      #1;
      check($sformatf("w8_rand_%0d", n), obs8(), refAdd(8, int'(rx), int'(ry), rc));
    end

    // Registered: outputs stay 0 through release until the first rising edge.
    @(negedge clk);
    bus4.operandX = 4'd1; bus4.operandY = 4'd1; bus4.carryIn = 1'b0;
    #1;
    check("reg_held_in_reset", obs4(), 9'd0);
    rst_n = 1'b1;
    #1;
    check("reg_released_no_edge", obs4(), 9'd0);
    @(posedge clk);
    #1;
    check("reg_first_capture", obs4(), 9'h002);

    // Latency: new inputs visible only after the next edge.
    @(negedge clk);
    bus4.operandX = 4'd3; bus4.operandY = 4'd5; bus4.carryIn = 1'b0;
    #1;
    check("reg_before_edge", obs4(), 9'h002);
    @(posedge clk);
    #1;
    check("reg_after_edge", obs4(), 9'h008);

    // Random stream through the register.
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rx = 8'($urandom_range(0, 15));
      ry = 8'($urandom_range(0, 15));
      rc = 1'($urandom);
      bus4.operandX = 4'(rx); bus4.operandY = 4'(ry); bus4.carryIn = rc;
      expQ.push_back(refAdd(4, int'(rx), int'(ry), rc));
      @(posedge clk);
      #1;
      check($sformatf("reg_stream_%0d", n), obs4(), expQ.pop_front());
    end

    // Mid-stream asynchronous reset discards the captured result.
    @(negedge clk);
    bus4.operandX = 4'd9; bus4.operandY = 4'd9; bus4.carryIn = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("reg_async_reset", obs4(), 9'd0);
    @(posedge clk);
    #1;
    check("reg_reset_holds", obs4(), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.operandX = 4'd2; bus4.operandY = 4'd4; bus4.carryIn = 1'b0;
    @(posedge clk);
    #1;
    check("reg_after_rerelease", obs4(), 9'h006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
